dc_video_tx: RTL and testbench

DC_VIDEO_TX -- requirements
Module: dc_video_tx

---
 rtl/dc_video_tx.sv | 128 ++++++++++++
 tb/tb_dc_video_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_video_tx.sv
// Raster timing generator and 24-to-12 bit pixel serializer for a multiplexed
// video DAC bus, with a frame-aligned switch between 480-line and 240p geometry.
module dc_video_tx #(
    parameter int H_TOTAL    = 1716,
    parameter int H_SYNC_LEN = 128,
    parameter int HSTART     = 257,
    parameter int WIDTH      = 720
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        line_doubler,
    input  logic        pix_valid,
    input  logic [23:0] pix_rgb,
    output logic        pix_ready,
    output logic [11:0] indata,
    output logic        _hsync,
    output logic        _vsync,
    output logic        frame_start,
    output logic        underflow
);
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = 10;
    localparam bit HSTART_ODD = (HSTART % 2) == 1;

    logic [HW-1:0] hCount_q, hCount_d;
    logic [VW-1:0] vCount_q, vCount_d;
    logic          mode_q, mode_d;
    logic [11:0]   holdLo_q, holdLo_d;
    logic [11:0]   indata_q, indata_d;
    logic          secondHalf_q, secondHalf_d;
    logic          underflow_q, underflow_d;
    logic          hsyncN_q, hsyncN_d;
    logic          vsyncN_q, vsyncN_d;
    logic          frameStart_q, frameStart_d;

    logic [VW-1:0] vTotal, vSyncLen, vStart, vHeight;
    logic          hWrap, vWrap, hActive, vActive;

    always_comb begin
        if (mode_q) begin
            vTotal   = 10'd263;
            vSyncLen = 10'd3;
            vStart   = 10'd18;
            vHeight  = 10'd240;
        end else begin
            vTotal   = 10'd525;
            vSyncLen = 10'd6;
            vStart   = 10'd40;
            vHeight  = 10'd480;
        end
    end

    assign hWrap   = hCount_q == HW'(H_TOTAL - 1);
    assign vWrap   = vCount_q == (vTotal - 10'd1);
    assign hActive = (hCount_q >= HW'(HSTART)) && (hCount_q < HW'(HSTART + 2 * WIDTH));
    assign vActive = (vCount_q >= vStart) && (vCount_q < (vStart + vHeight));

    // Each pixel spans two raw clocks; a new one is taken on the even offset from HSTART.
    assign pix_ready = reset && hActive && vActive && (hCount_q[0] == HSTART_ODD);

    // The geometry only changes at the frame boundary so a frame is never mixed.
    always_comb begin
        hCount_d = hWrap ? '0 : hCount_q + HW'(1);
        vCount_d = vCount_q;
        mode_d   = mode_q;
        if (hWrap) begin
            vCount_d = vWrap ? '0 : vCount_q + 10'd1;
            if (vWrap) begin
                mode_d = line_doubler;
            end
        end
    end

    always_comb begin
        holdLo_d     = holdLo_q;
        indata_d     = 12'h000;
        secondHalf_d = 1'b0;
        underflow_d  = underflow_q;
        if (pix_ready) begin
            secondHalf_d = 1'b1;
            if (pix_valid) begin
                holdLo_d = pix_rgb[11:0];
                indata_d = pix_rgb[23:12];
            end else begin
                holdLo_d    = 12'h000;
                underflow_d = 1'b1;
            end
        end else if (secondHalf_q) begin
            indata_d = holdLo_q;
        end
    end

    assign hsyncN_d     = !(hCount_q < HW'(H_SYNC_LEN));
    assign vsyncN_d     = !(vCount_q < vSyncLen);
    assign frameStart_d = (hCount_q == '0) && (vCount_q == '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            hCount_q     <= '0;
            vCount_q     <= '0;
            mode_q       <= line_doubler;
            holdLo_q     <= 12'h000;
            indata_q     <= 12'h000;
            secondHalf_q <= 1'b0;
            underflow_q  <= 1'b0;
            hsyncN_q     <= 1'b1;
            vsyncN_q     <= 1'b1;
            frameStart_q <= 1'b0;
        end else begin
            hCount_q     <= hCount_d;
            vCount_q     <= vCount_d;
            mode_q       <= mode_d;
            holdLo_q     <= holdLo_d;
            indata_q     <= indata_d;
            secondHalf_q <= secondHalf_d;
            underflow_q  <= underflow_d;
            hsyncN_q     <= hsyncN_d;
            vsyncN_q     <= vsyncN_d;
            frameStart_q <= frameStart_d;
        end
    end

    assign indata      = indata_q;
    assign _hsync      = hsyncN_q;
    assign _vsync      = vsyncN_q;
    assign frame_start = frameStart_q;
    assign underflow   = underflow_q;
endmodule

// File: tb/tb_dc_video_tx.sv
// Scoreboard bench for dc_video_tx using a shortened line so whole frames fit
// in a short run; per-line and per-frame timing is measured from the outputs.
module tb_dc_video_tx;
    localparam int HT     = 32;
    localparam int HS     = 4;
    localparam int HST    = 9;
    localparam int W      = 8;
    localparam int UF_IDX = 13;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        line_doubler = 1'b0;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_rgb = 24'h0;
    logic        pix_ready;
    logic [11:0] indata;
    logic        _hsync;
    logic        _vsync;
    logic        frame_start;
    logic        underflow;

    dc_video_tx #(
        .H_TOTAL(HT),
        .H_SYNC_LEN(HS),
        .HSTART(HST),
        .WIDTH(W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .line_doubler(line_doubler),
        .pix_valid(pix_valid),
        .pix_rgb(pix_rgb),
        .pix_ready(pix_ready),
        .indata(indata),
        ._hsync(_hsync),
        ._vsync(_vsync),
        .frame_start(frame_start),
        .underflow(underflow)
    );

    always #5 clock = ~clock;

    int compared = 0;
    int mismatched = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rstVal, input logic ldVal);
        @(posedge clock);
        #2;
        reset = rstVal;
        line_doubler = ldVal;
    endtask

    logic [23:0] vecRgb[4];
    logic [11:0] vecHi[4];
    logic [11:0] vecLo[4];
    logic [12:0] expQ[$];
    int          pixIdx = 0;

    // Driver: offers a pixel only when the DUT asks and queues the expected halves.
    always @(negedge clock) begin
        if (pix_ready) begin
            if (pixIdx == UF_IDX) begin
                pix_valid = 1'b0;
                pix_rgb   = 24'hDEADBE;
                expQ.push_back({1'b1, 12'h000});
                expQ.push_back({1'b0, 12'h000});
            end else begin
                pix_valid = 1'b1;
                pix_rgb   = vecRgb[pixIdx % 4];
                expQ.push_back({1'b0, vecHi[pixIdx % 4]});
                expQ.push_back({1'b0, vecLo[pixIdx % 4]});
            end
            pixIdx++;
        end else begin
            pix_valid = 1'b1;
            pix_rgb   = 24'h777777;
        end
    end

    typedef struct {
        int len;
        int vsLow;
        int firstLine;
        int lastLine;
        int active;
    } frameStat_t;

    frameStat_t frameLog[$];
    logic rstPrev = 1'b0, rstOld = 1'b0, rdy1 = 1'b0, rdy2 = 1'b0;
    logic prevHs = 1'b1, prevVs = 1'b1;
    bit   lineValid = 1'b0, frameValid = 1'b0, expUf = 1'b0;
    int   lineCyc = 0, frameCyc = 0, lineRdy = 0, lineFirstH = 0, lineLastH = 0;
    int   fVsLow = -1, fFirst = -1, fLast = -1, fActive = 0;

    // Monitor: rstPrev holds the reset level seen by the most recent rising edge.
    always @(negedge clock) begin
        logic [12:0] e;
        bit hsFall, vsFall, hsRise, vsRise;
        int line;
        frameStat_t st;
        lineCyc++;
        frameCyc++;
        hsFall = prevHs && !_hsync;
        hsRise = !prevHs && _hsync;
        vsFall = prevVs && !_vsync;
        vsRise = !prevVs && _vsync;
        if (!reset) checkOutput("ready_in_reset", pix_ready, 0);
        if (!rstPrev) begin
            checkOutput("reset_indata", indata, 0);
            checkOutput("reset_hsync", _hsync, 1);
            checkOutput("reset_vsync", _vsync, 1);
            checkOutput("reset_frame_start", frame_start, 0);
            checkOutput("reset_underflow", underflow, 0);
            expQ.delete();
            expUf = 1'b0;
            rdy1 = 1'b0;
            rdy2 = 1'b0;
            lineValid = 1'b0;
            frameValid = 1'b0;
        end else begin
            if (!rstOld) begin
                checkOutput("release_hsync", _hsync, 0);
                checkOutput("release_vsync", _vsync, 0);
                checkOutput("release_frame_start", frame_start, 1);
            end
            if (rdy1 || rdy2) begin
                if (expQ.size() == 0) begin
                    checkOutput("scoreboard_depth", expQ.size(), 1);
                end else begin
                    e = expQ.pop_front();
                    if (e[12]) expUf = 1'b1;
                    checkOutput("indata", indata, e[11:0]);
                end
            end else begin
                checkOutput("indata_idle", indata, 0);
            end
            checkOutput("underflow", underflow, expUf);
            checkOutput("frame_start", frame_start, vsFall);
            if (vsFall) checkOutput("vsync_with_hsync", hsFall, 1);
            if (hsFall) begin
                if (lineValid) begin
                    checkOutput("line_len", lineCyc - 1, HT);
                    if (lineRdy > 0) begin
                        checkOutput("line_ready_count", lineRdy, W);
                        checkOutput("line_first_h", lineFirstH, HST);
                        checkOutput("line_last_h", lineLastH, HST + 2 * W - 2);
                    end
                end
                lineValid = 1'b1;
                lineCyc = 1;
                lineRdy = 0;
            end
            if (hsRise && lineValid) checkOutput("hsync_low", lineCyc - 1, HS);
            if (vsFall) begin
                if (frameValid) begin
                    st = '{frameCyc - 1, fVsLow, fFirst, fLast, fActive};
                    frameLog.push_back(st);
                end
                frameValid = 1'b1;
                frameCyc = 1;
                fVsLow = -1;
                fFirst = -1;
                fLast = -1;
                fActive = 0;
            end
            if (vsRise && frameValid) fVsLow = frameCyc - 1;
            if (pix_ready && frameValid) begin
                line = frameCyc / HT;
                if (fFirst < 0) fFirst = line;
                if (line != fLast) fActive++;
                fLast = line;
            end
            if (pix_ready && lineValid) begin
                if (lineRdy == 0) lineFirstH = lineCyc;
                lineLastH = lineCyc;
                lineRdy++;
            end
        end
        rdy2 = rdy1;
        rdy1 = pix_ready;
        prevHs = _hsync;
        prevVs = _vsync;
        rstOld = rstPrev;
        rstPrev = reset;
    end

    initial begin
        int n;
        vecRgb[0] = 24'hA5C33C; vecHi[0] = 12'hA5C; vecLo[0] = 12'h33C;
        vecRgb[1] = 24'h123456; vecHi[1] = 12'h123; vecLo[1] = 12'h456;
        vecRgb[2] = 24'hFF00FF; vecHi[2] = 12'hFF0; vecLo[2] = 12'h0FF;
        vecRgb[3] = 24'h0F1E2D; vecHi[3] = 12'h0F1; vecLo[3] = 12'hE2D;

        repeat (3) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        repeat (5000) @(posedge clock);
        #2 line_doubler = 1'b1;

        n = 0;
        while (frameLog.size() < 2 && n < 30000) begin
            @(posedge clock);
            n++;
        end
        if (frameLog.size() < 2) begin
            checkOutput("frame_log_timeout", frameLog.size(), 2);
        end else begin
            checkOutput("f0_len", frameLog[0].len, 525 * HT);
            checkOutput("f0_vsync_low", frameLog[0].vsLow, 6 * HT);
            checkOutput("f0_first_line", frameLog[0].firstLine, 40);
            checkOutput("f0_last_line", frameLog[0].lastLine, 519);
            checkOutput("f0_active_lines", frameLog[0].active, 480);
            checkOutput("f1_len", frameLog[1].len, 263 * HT);
            checkOutput("f1_vsync_low", frameLog[1].vsLow, 3 * HT);
            checkOutput("f1_first_line", frameLog[1].firstLine, 18);
            checkOutput("f1_last_line", frameLog[1].lastLine, 257);
            checkOutput("f1_active_lines", frameLog[1].active, 240);
        end

        n = 0;
        @(negedge clock);
        while (!pix_ready && n < 2000) begin
            @(negedge clock);
            n++;
        end
        checkOutput("active_pixel_reached", pix_ready, 1);
        applyStimulus(1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        repeat (4 * HT) @(posedge clock);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
